alu_exec: RTL
=============

# alu_exec

Multi-cycle execution unit that consumes the 4-bit ALU operation code produced by the ALU controller, together with the two register operands and the instruction shamt field. It returns a registered result under a START/DONE handshake. Logic and arithmetic operations complete in one cycle. Shifts run on a one-bit-per-cycle serial shifter, so latency depends on the shift amount. It sits in the execute stage between the register-file read ports and the writeback mux.

## Interface
- WIDTH, 32, datapath width.
- SAW, 5, shift-amount width; must equal log2(WIDTH).

- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- START  in  1  request; sampled only when BUSY=0
- CODE  in  4  ALU operation code
- A  in  WIDTH  operand rs
- B  in  WIDTH  operand rt
- SHAMT  in  SAW  immediate shift amount
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle pulse; RESULT, ZERO, OVF and ERR are valid
- RESULT  out  WIDTH  registered result; holds until the next DONE
- ZERO  out  1  RESULT==0, updated with RESULT
- OVF  out  1  signed overflow for ADD/SUB, 0 otherwise
- ERR  out  1  illegal CODE flag, updated with RESULT

## Operation
- Codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR.
  - 0101 SLTU (unsigned A<B gives 1, else 0); 0110 SUB (A−B); 0111 SLT (signed A<B).
  - 1000 SLL B by SHAMT; 1001 SLLV B by A[SAW-1:0].
  - 1010 SRL B by SHAMT; 1011 SRLV B by A[SAW-1:0].
  - 1100 SRA B by SHAMT; 1101 SRAV B by A[SAW-1:0].
  - 1110, 1111, or any X/Z bit: illegal.
- Arithmetic:
  - ADD and SUB wrap modulo 2^WIDTH.
  - OVF=1 when both operands (for SUB: A and ~B) share a sign that differs from the result sign.
- Shifts:
  - SRL zero-fills.
  - SRA fills with B[WIDTH-1], the sign captured at START.
- On acceptance, CODE, A, B and the effective shift amount are captured into internal registers. Later changes on the input ports have no effect on the operation in flight.
- FSM states: IDLE, EXEC, SHIFT.
  - IDLE: START=1 → capture operands, go to EXEC.
  - EXEC, non-shift, illegal, or shift amount 0: register the result, pulse DONE, go to IDLE.
  - EXEC, shift amount n≥1: perform the first 1-bit shift, load cnt=n−1. If cnt=0, pulse DONE and go to IDLE; otherwise go to SHIFT.
  - SHIFT: one 1-bit shift per cycle, cnt decrements. When cnt reaches 0, write RESULT, pulse DONE and go to IDLE.
- Illegal CODE: RESULT=0, ERR=1, OVF=0, ZERO=1, latency 1.
- A legal operation clears ERR.

## Timing
- START sampled at edge k. Latency L = max(1, n) edges, where n=0 for non-shift codes.
- DONE is high for exactly the cycle after edge k+L.
- BUSY is high in the cycles after edges k through k+L−1. It falls in the same cycle DONE rises.
- BUSY=0 during the DONE cycle. A START in the DONE cycle is accepted, giving back-to-back operation with no bubble.
- START while BUSY=1 is ignored and not queued.
- Maximum latency is 2^SAW−1 edges (31 for WIDTH 32).
- Reset values: BUSY=0, DONE=0, RESULT=0, ZERO=1, OVF=0, ERR=0, state IDLE, cnt=0.
- RST at any edge, including mid-shift, aborts the operation. No DONE is produced, and outputs take their reset values at that edge.
- RST=1 together with START: reset wins and START is discarded.

## Test plan
- ADD overflow: START, CODE=0010, A=0x7FFFFFFF, B=1 → DONE at k+1, RESULT=0x80000000, OVF=1, ZERO=0, BUSY never high in the DONE cycle.
- SUB and compares:
  - SUB A=5, B=5 → RESULT=0, ZERO=1, OVF=0.
  - SLT A=0xFFFFFFFF, B=1 → RESULT=1.
  - SLTU with the same operands → RESULT=0.
- Serial shifts:
  - SRA, B=0x80000000, SHAMT=31 → BUSY high 31 cycles, DONE at k+31, RESULT=0xFFFFFFFF.
  - SRLV, B=0xF0000000, A=4 → DONE at k+4, RESULT=0x0F000000.
- Shift boundaries:
  - SLL with SHAMT=0 → RESULT=B, DONE at k+1.
  - SLL, B=1, SHAMT=1 → RESULT=2, DONE at k+1.
  - Change A/B/SHAMT while BUSY → result unchanged.
- Handshake and illegal codes:
  - START held high continuously with alternating ADD and SLL-by-3 → one DONE per accepted op, starts accepted only when BUSY=0.
  - CODE=1110 → RESULT=0, ERR=1, DONE at k+1.
- Reset: assert RST at edge k+10 during a 20-bit SRL → no DONE, outputs at reset values next cycle, and a fresh START is accepted the cycle after RST deasserts.

Source files
------------

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arithmetic, serial one-bit-per-cycle shifter.
// Operands are captured on START; RESULT/ZERO/OVF/ERR update together with the DONE pulse.
module alu_exec #(
  parameter int WIDTH = 32,
  parameter int SAW   = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [3:0]       CODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SAW-1:0]   SHAMT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             OVF,
  output logic             ERR,
  output logic [1:0]       DBG_STATE
);

  // Handshake: START is sampled on a rising edge only while BUSY=0 (including the
  // DONE cycle); exactly one DONE pulse follows each accepted START unless RST intervenes.
  // START while BUSY=1 is dropped, never queued.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       code_q, code_d;
  logic             ill_q, ill_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             sign_q, sign_d;
  logic [SAW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             accept;
  logic             shift_en;
  logic             finish;
  logic             is_shift;
  logic             cnt_gt1;
  logic             cnt_one;
  logic [SAW-1:0]   amt_in;

  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic             ovf_add;
  logic             ovf_sub;
  logic [WIDTH-1:0] sh_step;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] res_new;

  assign is_shift = code_q[3] & ~ill_q;
  assign cnt_gt1  = (cnt_q > SAW'(1));
  assign cnt_one  = (cnt_q == SAW'(1));
  assign amt_in   = CODE[0] ? A[SAW-1:0] : SHAMT;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = S_EXEC;
      S_EXEC:  state_d = (is_shift && cnt_gt1) ? S_SHIFT : S_IDLE;
      S_SHIFT: if (cnt_one) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs / datapath controls ----------------
  always_comb begin
    accept   = 1'b0;
    shift_en = 1'b0;
    finish   = 1'b0;
    BUSY     = 1'b1;
    case (state_q)
      S_IDLE: begin
        BUSY   = 1'b0;
        accept = START;
      end
      S_EXEC: begin
        shift_en = is_shift && (cnt_q != '0);
        finish   = !(is_shift && cnt_gt1);
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        finish   = cnt_one;
      end
      default: begin
        BUSY = 1'b0;
      end
    endcase
  end

  // ---------------- Datapath: single-cycle operations ----------------
  always_comb begin
    add_res = a_q + sh_q;
    sub_res = a_q - sh_q;
    ovf_add = (a_q[WIDTH-1] == sh_q[WIDTH-1]) && (add_res[WIDTH-1] != a_q[WIDTH-1]);
    ovf_sub = (a_q[WIDTH-1] != sh_q[WIDTH-1]) && (sub_res[WIDTH-1] != a_q[WIDTH-1]);
    alu_res = '0;
    alu_ovf = 1'b0;
    case (code_q[2:0])
      3'b000: alu_res = a_q & sh_q;
      3'b001: alu_res = a_q | sh_q;
      3'b010: begin
        alu_res = add_res;
        alu_ovf = ovf_add;
      end
      3'b011: alu_res = a_q ^ sh_q;
      3'b100: alu_res = ~(a_q | sh_q);
      3'b101: alu_res = {{(WIDTH-1){1'b0}}, (a_q < sh_q)};
      3'b110: begin
        alu_res = sub_res;
        alu_ovf = ovf_sub;
      end
      3'b111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(sh_q))};
      default: alu_res = '0;
    endcase
  end

  // One-bit shift step; SRA refills with the sign captured at START.
  always_comb begin
    case (code_q[2:1])
      2'b00:   sh_step = {sh_q[WIDTH-2:0], 1'b0};
      2'b01:   sh_step = {1'b0, sh_q[WIDTH-1:1]};
      default: sh_step = {sign_q, sh_q[WIDTH-1:1]};
    endcase
  end

  // ---------------- Datapath: next-state ----------------
  always_comb begin
    code_d  = code_q;
    ill_d   = ill_q;
    a_d     = a_q;
    sign_d  = sign_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    done_d  = finish;
    res_new = '0;

    if (accept) begin
      code_d = CODE;
      ill_d  = $isunknown(CODE) || (CODE[3:1] == 3'b111);
      a_d    = A;
      sh_d   = B;
      sign_d = B[WIDTH-1];
      cnt_d  = amt_in;
    end else if (shift_en) begin
      sh_d  = sh_step;
      cnt_d = cnt_q - SAW'(1);
    end

    if (finish) begin
      if (ill_q) begin
        res_new = '0;
        ovf_d   = 1'b0;
        err_d   = 1'b1;
      end else if (is_shift) begin
        res_new = (cnt_q == '0) ? sh_q : sh_step;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
      end else begin
        res_new = alu_res;
        ovf_d   = alu_ovf;
        err_d   = 1'b0;
      end
      res_d  = res_new;
      zero_d = (res_new == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      code_q <= '0;
      ill_q  <= 1'b0;
      a_q    <= '0;
      sh_q   <= '0;
      sign_q <= 1'b0;
      cnt_q  <= '0;
      res_q  <= '0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      code_q <= code_d;
      ill_q  <= ill_d;
      a_q    <= a_d;
      sh_q   <= sh_d;
      sign_q <= sign_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
      done_q <= done_d;
    end
  end

  assign DONE      = done_q;
  assign RESULT    = res_q;
  assign ZERO      = zero_q;
  assign OVF       = ovf_q;
  assign ERR       = err_q;
  assign DBG_STATE = state_q;

endmodule
